// File: rtl/gcn_mm_pkg.sv
// Shared types and constants for the GCN matmul scheduler and its arbiter.
package gcn_mm_pkg;

    localparam int ELEM_W = 8;
    localparam int MAT_W  = 4 * ELEM_W;

    // MSB-first packing: {m00, m01, m10, m11}
    typedef logic [3:0][ELEM_W-1:0] mat2x2_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/gcn_rr_arb.sv
// Combinational round-robin pick: first valid requester above last_grant, wrapping.
module gcn_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NREQ);
            if (!any && valid[cand]) begin
                any             = 1'b1;
                grant_idx       = cand;
                grant[cand]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcn_mm_sched.sv
// Shares one 2x2 int8 matmul engine between NREQ requesters: round-robin accept,
// single-cycle start, watchdog-guarded wait, and result return to the owner.
module gcn_mm_sched
    import gcn_mm_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [MAT_W*NREQ-1:0] req_a,
    input  logic [MAT_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [MAT_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [MAT_W-1:0]      eng_a,
    output logic [MAT_W-1:0]      eng_b,
    input  logic                  eng_done,
    input  logic [MAT_W-1:0]      eng_res,
    output logic                  busy,
    output logic                  stray_done,
    output logic [CNT_W-1:0]      jobs_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    sched_state_t     state, state_nxt;
    logic [IDX_W-1:0] last_grant, owner, grant_idx;
    logic [NREQ-1:0]  grant;
    logic             any;
    mat2x2_t          a_sel [NREQ];
    mat2x2_t          b_sel [NREQ];
    mat2x2_t          op_a, op_b, res;
    logic             err;
    logic [WD_W-1:0]  wdog;
    logic [CNT_W-1:0] jobs;
    logic             stray;
    logic             timeout_hit;

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign a_sel[r] = req_a[MAT_W*r +: MAT_W];
        assign b_sel[r] = req_b[MAT_W*r +: MAT_W];
    end

    gcn_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (any)
    );

    // Counter reaches TIMEOUT-1 on this edge; a coincident eng_done takes priority.
    assign timeout_hit = (state == WAIT) && (wdog == WD_W'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = grant;
                if (any) state_nxt = ISSUE;
            end
            ISSUE: begin
                eng_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_done || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = NREQ'(1) << owner;
                if (rsp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NREQ - 1);
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            err        <= 1'b0;
            wdog       <= '0;
            jobs       <= '0;
            stray      <= 1'b0;
        end else begin
            if (state == IDLE && any) begin
                owner <= grant_idx;
                op_a  <= a_sel[grant_idx];
                op_b  <= b_sel[grant_idx];
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + 1'b1;
            end
            if (state == WAIT) begin
                if (eng_done) begin
                    res <= eng_res;
                    err <= 1'b0;
                end else if (timeout_hit) begin
                    res <= '0;
                    err <= 1'b1;
                end
            end
            if (state == RESP && rsp_ready[owner]) begin
                last_grant <= owner;
                jobs       <= jobs + 1'b1;
            end
            if (eng_done && state != WAIT) stray <= 1'b1;
        end
    end

    assign eng_a      = op_a;
    assign eng_b      = op_b;
    assign rsp_data   = res;
    assign rsp_err    = err;
    assign jobs_done  = jobs;
    assign stray_done = stray;

endmodule

// File: tb/tb_gcn_mm_sched.sv
// Directed bench for gcn_mm_sched with a behavioural 2x2 int8 engine of programmable latency.
module tb_gcn_mm_sched;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*NREQ-1:0]    req_a, req_b;
    logic [31:0]           rsp_data, eng_a, eng_b, eng_res, res_pend;
    logic                  rsp_err, eng_start, eng_done, eng_done_m, stray_pulse;
    logic                  busy, stray_done;
    logic [CNT_W-1:0]      jobs_done;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 8;
    int cd;

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    gcn_mm_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_res    (eng_res),
        .busy       (busy),
        .stray_done (stray_done),
        .jobs_done  (jobs_done)
    );

    function automatic logic [31:0] mm_model(input logic [31:0] a, input logic [31:0] b);
        logic signed [7:0] x [4];
        logic signed [7:0] y [4];
        logic [7:0]        c [4];
        for (int i = 0; i < 4; i++) begin
            x[i] = a[31-8*i -: 8];
            y[i] = b[31-8*i -: 8];
        end
        c[0] = 8'(int'(x[0]) * int'(y[0]) + int'(x[1]) * int'(y[2]));
        c[1] = 8'(int'(x[0]) * int'(y[1]) + int'(x[1]) * int'(y[3]));
        c[2] = 8'(int'(x[2]) * int'(y[0]) + int'(x[3]) * int'(y[2]));
        c[3] = 8'(int'(x[2]) * int'(y[1]) + int'(x[3]) * int'(y[3]));
        return {c[0], c[1], c[2], c[3]};
    endfunction

    // Engine: done arrives lat cycles after the start cycle; lat == 0 means it never answers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done_m <= 1'b0;
            eng_res    <= '0;
            res_pend   <= '0;
            cd         <= 0;
        end else begin
            eng_done_m <= 1'b0;
            if (eng_start) begin
                res_pend <= mm_model(eng_a, eng_b);
                cd       <= (lat > 1) ? lat - 1 : 0;
            end else if (cd > 1) begin
                cd <= cd - 1;
            end else if (cd == 1) begin
                cd         <= 0;
                eng_done_m <= 1'b1;
                eng_res    <= res_pend;
            end
        end
    end

    assign eng_done = eng_done_m | stray_pulse;

    function automatic logic [31:0] onehot(input int r);
        return 32'(1) << r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
    endtask

    task automatic wait_accept(input int r, input string nm);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, 32'(req_ready), onehot(r));
    endtask

    task automatic check_start(input logic [31:0] a, input logic [31:0] b, input string nm);
        chk({nm, "_start"}, 32'(eng_start), 32'd1);
        chk({nm, "_eng_a"}, eng_a, a);
        chk({nm, "_eng_b"}, eng_b, b);
        chk({nm, "_ready_issue"}, 32'(req_ready), 32'd0);
    endtask

    task automatic wait_resp(input int r, input logic [31:0] exp_data, input logic exp_err,
                             input int exp_lat, input string nm);
        int n = 0;
        int extra = 0;
        while (rsp_valid == '0 && n < 40) begin
            tick();
            n++;
            if (eng_start) extra++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk({nm, "_starts"}, 32'(extra), 32'd0);
        chk({nm, "_valid"}, 32'(rsp_valid), onehot(r));
        chk({nm, "_data"}, rsp_data, exp_data);
        chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_rsp_data"}, rsp_data, 32'd0);
        chk({nm, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({nm, "_eng_a"}, eng_a, 32'd0);
        chk({nm, "_eng_b"}, eng_b, 32'd0);
        chk({nm, "_jobs"}, 32'(jobs_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 32'h01020304, 32'h05060708, 32'h13162B32};
        tbl[1] = '{1, 32'h01000001, 32'h11223344, 32'h11223344};
        tbl[2] = '{0, 32'h02000002, 32'h01020304, 32'h02040608};
        tbl[3] = '{1, 32'hFF000001, 32'h01020304, 32'hFFFE0304};

        rst_n       = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = '0;
        stray_pulse = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        chk("reset_stray", 32'(stray_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single job, response held one extra cycle before acceptance
        lat = 8;
        set_req(0, 32'h01020304, 32'h05060708);
        req_valid = 2'b01;
        wait_accept(0, "t1");
        tick();
        req_valid = 2'b00;
        check_start(32'h01020304, 32'h05060708, "t1");
        wait_resp(0, 32'h13162B32, 1'b0, 9, "t1");
        tick();
        chk("t1_hold_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("t1_after_valid", 32'(rsp_valid), 32'd0);
        chk("t1_jobs", 32'(jobs_done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // Alternating grants with both requesters continuously valid
        apply_reset();
        rsp_ready = 2'b11;
        set_req(tbl[0].r, tbl[0].a, tbl[0].b);
        set_req(tbl[1].r, tbl[1].a, tbl[1].b);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_accept(tbl[i].r, $sformatf("t2_%0d", i));
            tick();
            if (i + 2 < 4) set_req(tbl[i].r, tbl[i+2].a, tbl[i+2].b);
            else req_valid[tbl[i].r] = 1'b0;
            check_start(tbl[i].a, tbl[i].b, $sformatf("t2_%0d", i));
            wait_resp(tbl[i].r, tbl[i].exp, 1'b0, 9, $sformatf("t2_%0d", i));
            tick();
        end
        chk("t2_jobs", 32'(jobs_done), 32'd4);

        // Engine silent: watchdog fails the job, then a healthy job follows
        lat = 0;
        set_req(0, 32'h01020304, 32'h05060708);
        req_valid = 2'b01;
        wait_accept(0, "t3a");
        tick();
        req_valid = 2'b00;
        check_start(32'h01020304, 32'h05060708, "t3a");
        wait_resp(0, 32'h0, 1'b1, 16, "t3a");
        tick();
        lat = 8;
        set_req(0, 32'h02000002, 32'h11223344);
        req_valid = 2'b01;
        wait_accept(0, "t3b");
        tick();
        req_valid = 2'b00;
        check_start(32'h02000002, 32'h11223344, "t3b");
        wait_resp(0, 32'h22446688, 1'b0, 9, "t3b");
        tick();
        chk("t3_jobs", 32'(jobs_done), 32'd6);

        // Stalled responder blocks the other requester; non-owner ready is ignored
        rsp_ready = 2'b10;
        set_req(0, 32'h01000001, 32'hDEADBEEF);
        req_valid = 2'b01;
        wait_accept(0, "t4a");
        tick();
        set_req(1, 32'h01020304, 32'h05060708);
        req_valid = 2'b10;
        check_start(32'h01000001, 32'hDEADBEEF, "t4a");
        wait_resp(0, 32'hDEADBEEF, 1'b0, 9, "t4a");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_stall_valid", 32'(rsp_valid), 32'd1);
            chk("t4_stall_data", rsp_data, 32'hDEADBEEF);
            chk("t4_stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b11;
        tick();
        chk("t4_grant_next", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        check_start(32'h01020304, 32'h05060708, "t4b");
        wait_resp(1, 32'h13162B32, 1'b0, 9, "t4b");
        tick();
        chk("t4_jobs", 32'(jobs_done), 32'd8);

        // Reset mid-WAIT aborts silently; a late done is flagged as stray
        set_req(0, 32'h01020304, 32'h05060708);
        req_valid = 2'b01;
        wait_accept(0, "t5a");
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("t5_busy_wait", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        stray_pulse = 1'b1;
        tick();
        stray_pulse = 1'b0;
        chk("t5_stray", 32'(stray_done), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("t5_busy", 32'(busy), 32'd0);
        set_req(0, 32'h01020304, 32'h05060708);
        req_valid = 2'b01;
        wait_accept(0, "t5b");
        tick();
        req_valid = 2'b00;
        check_start(32'h01020304, 32'h05060708, "t5b");
        wait_resp(0, 32'h13162B32, 1'b0, 9, "t5b");
        tick();
        chk("t5_jobs", 32'(jobs_done), 32'd1);
        chk("t5_stray_sticky", 32'(stray_done), 32'd1);

        // Counter wrap over 17 jobs, then done landing on the timeout cycle
        apply_reset();
        rsp_ready = 2'b11;
        set_req(0, 32'h01020304, 32'h05060708);
        req_valid = 2'b01;
        for (int i = 0; i < 17; i++) begin
            wait_accept(0, "t6");
            tick();
            check_start(32'h01020304, 32'h05060708, "t6");
            wait_resp(0, 32'h13162B32, 1'b0, 9, "t6");
            tick();
        end
        chk("t6_jobs_wrap", 32'(jobs_done), 32'd1);
        lat = 15;
        wait_accept(0, "t6c");
        tick();
        req_valid = 2'b00;
        check_start(32'h01020304, 32'h05060708, "t6c");
        wait_resp(0, 32'h13162B32, 1'b0, 16, "t6c");
        tick();
        chk("t6_jobs_final", 32'(jobs_done), 32'd2);
        chk("t6_stray", 32'(stray_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcn_mm_sched.md
Name: gcn_mm_sched

Overview:
Scheduler and arbiter that shares one 2x2 int8 matrix-multiply engine between NREQ requesters, e.g. the GCN aggregation (A·X) and combination (X·W) stages.
- Accepts one job at a time via valid/ready, round-robin across requesters.
- Issues a start pulse to the engine and holds operands stable until the engine finishes.
- Waits for done, with a watchdog timeout.
- Returns the result to the owning requester via valid/ready.
- Sits between the layer-level control FSM and the matmul engine.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 64, max cycles in WAIT before the job is failed
CNT_W, 8, width of the completed-job counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester job valid
req_ready  out  NREQ  one-hot accept, asserted only in IDLE for the granted requester
req_a  in  32*NREQ  flattened A operands; requester r at [32r+31:32r]
req_b  in  32*NREQ  flattened B operands, same layout
rsp_valid  out  NREQ  one-hot result valid
rsp_ready  in  NREQ  per-requester result accept
rsp_data  out  32  result matrix, shared by all requesters
rsp_err  out  1  result is a timeout failure
eng_start  out  1  single-cycle engine start
eng_a  out  32  operand A to engine
eng_b  out  32  operand B to engine
eng_done  in  1  single-cycle engine completion
eng_res  in  32  engine result, valid with eng_done
busy  out  1  state != IDLE
stray_done  out  1  sticky: eng_done seen outside WAIT
jobs_done  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
Matrix packing, MSB-first: {m00,m01,m10,m11}, 8 bits each. The scheduler never alters data bits.

Reset values:
- Every output 0.
- FSM in IDLE.
- last_grant = NREQ-1, so requester 0 has first priority.
- Reset mid-job aborts the job silently; no response is produced.

States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first valid requester searching from last_grant+1 upward, with wrap.
  - req_ready[g]=1 in that same cycle (combinational from state, req_valid and last_grant).
  - Latch req_a[g], req_b[g] and g at the clock edge, then go to ISSUE.
- ISSUE: eng_start=1 for exactly one cycle; clear watchdog; go to WAIT.
  - eng_a/eng_b drive the latched operands from ISSUE until the next job is latched.
- WAIT: watchdog increments each cycle.
  - On eng_done: capture eng_res into rsp_data, rsp_err=0, go to RESP.
  - If the watchdog reaches TIMEOUT-1 without eng_done: rsp_data=0, rsp_err=1, go to RESP.
  - eng_done in the same cycle as timeout: done wins.
- RESP: rsp_valid[g]=1; rsp_data and rsp_err are held stable.
  - When rsp_ready[g]=1: last_grant<=g, jobs_done++, go to IDLE.
  - rsp_ready already high on RESP entry means RESP lasts 1 cycle.
  - No new grant is issued while in RESP.

Latency: accept edge to eng_start is 1 cycle. eng_done at cycle t gives rsp_valid at t+1.

Throughput: at most one job in flight. Minimum 3 cycles of overhead plus engine latency.

Requester obligations: keep req_valid, req_a and req_b stable until req_ready. A requester that drops req_valid before grant is simply skipped.

Boundary cases:
- eng_done in IDLE/ISSUE/RESP: ignored for data, sets stray_done (cleared only by reset).
- rsp_ready of non-owners: ignored.
- Stalled responder: blocks all requesters (no bypass).

Decomposition:
- Package gcn_mm_pkg holds:
  - ELEM_W=8, MAT_W=32
  - typedef mat2x2_t (packed 4×8)
  - enum sched_state_t {IDLE, ISSUE, WAIT, RESP}
- Sub-module gcn_rr_arb(NREQ): combinational round-robin pick.
  - Inputs: valid vector, last_grant.
  - Outputs: one-hot grant, grant index, any.

Test Plan:
1. Engine model, latency 8. req0: A=0x01020304, B=0x05060708 → one eng_start 1 cycle after accept; rsp_valid[0] 9 cycles after start; rsp_data=0x13162B32, rsp_err=0; jobs_done=1.
2. After reset, req0 and req1 both continuously valid with distinct data → grants alternate 0,1,0,1 over 4 jobs; each rsp goes to the correct requester with the correct product.
3. Engine never asserts done, TIMEOUT=16 → rsp_err=1, rsp_data=0 entered 16 cycles after eng_start. A following job with working engine returns err=0 and the correct data.
4. rsp_ready[0] held low 10 cycles while req1 valid → rsp_valid[0] and rsp_data stable, req_ready[1]=0 throughout; req1 granted the cycle after the handshake completes.
5. rst_n low during WAIT, then eng_done pulses 2 cycles after release → all outputs 0, no rsp_valid, stray_done=1; next job completes normally.
6. CNT_W=4, 17 back-to-back jobs → jobs_done reads 1 after the 17th; eng_done coinciding with the timeout cycle → rsp_err=0 with the engine data.
